cereal_rx: RTL
==============

// Module: cereal_rx
// PURPOSE
//   8N1 serial receiver; the downstream stage of the keyboard/cereal transmit path.
//   Oversamples the serial line (the cereal output) in the sysclk domain and
//   recovers bytes, LSB first. Received bytes go into a small FWFT FIFO; frame and
//   overrun errors are flagged. Feeds display/loopback logic.
// PARAMETERS
//   CLKS_PER_BIT  5208  sysclk cycles per bit; >=4 (16 in sim benches)
//   DEPTH         4     FIFO entries, power of two, >=2
//   AW            2     log2(DEPTH)
// PORTS
//   sysclk     in   1  system clock, all logic on posedge
//   rst_n      in   1  asynchronous active-low reset
//   rxd        in   1  serial line, idle high, asynchronous to sysclk
//   rd_en      in   1  pop head entry; ignored when empty
//   clr_err    in   1  clears sticky overrun
//   rd_data    out  8  FIFO head (first-word fall-through); valid only when !empty
//   empty      out  1  FIFO holds 0 entries
//   full       out  1  FIFO holds DEPTH entries
//   busy       out  1  high in any state other than IDLE
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   overrun    out  1  sticky: byte dropped because FIFO was full
// BEHAVIOUR
//   Reset (async, rst_n=0): both synchronizer flops=1, state=IDLE, bit/cycle
//     counters=0, FIFO pointers=0, empty=1, full=0, busy=0, frame_err=0,
//     overrun=0, rd_data=8'h00.
//   rxd passes through a 2-flop synchronizer (rx_s); only rx_s is used.
//   cnt: cycle counter, width $clog2(CLKS_PER_BIT); reset to 0 on every state entry.
//   FSM:
//     IDLE : rx_s==0 -> START.
//     START: at cnt==CLKS_PER_BIT/2-1, sample rx_s: 0 -> DATA;
//            1 -> IDLE (glitch, nothing stored).
//     DATA : at cnt==CLKS_PER_BIT-1, shift rx_s into shreg[7] (shift right);
//            after 8th sample (bitcnt==7) -> STOP, else bitcnt++.
//     STOP : at cnt==CLKS_PER_BIT-1, sample rx_s:
//            1 -> push shreg, -> IDLE;
//            0 -> frame_err=1 for exactly 1 cycle, byte discarded, -> WAITHI.
//     WAITHI: stay until rx_s==1, then -> IDLE (no restart on held-low line/break).
//   Push rules: push when FIFO not full, or when full with rd_en in the same cycle
//     (pop+push both take effect; count unchanged).
//     Full with no rd_en: byte dropped, overrun<=1.
//   overrun: clears only on clr_err; a set in the same cycle as clr_err wins.
//   Pop: rd_en && !empty advances rd ptr; next head appears on rd_data next cycle.
//   Simultaneous push+pop on an empty FIFO: pop ignored, push accepted.
//   Latency: empty deasserts on the cycle after the stop-bit sample edge; the
//     stored byte is on rd_data in that same cycle.
//   Pointers wrap modulo DEPTH; count kept in AW+1 bits; full = (count==DEPTH).
//   rst_n asserted mid-frame aborts the frame; FIFO contents are lost.
// TESTING (CLKS_PER_BIT=16, DEPTH=4)
//   Send 8'hA5 8N1 -> busy high ~10 bit times; empty falls; rd_data==8'hA5;
//     rd_en pulse -> empty=1.
//   Send 8'h00, 8'hFF, 8'h3C back-to-back, no reads -> 3 entries; pops return
//     them in order; full never asserts.
//   Send 5 bytes without reads -> full after 4th; 5th dropped, overrun=1;
//     first 4 pops return bytes 1-4; clr_err clears overrun.
//   Frame 8'h55 with stop bit low -> frame_err single-cycle pulse; FIFO unchanged;
//     FSM stays in WAITHI until rxd high; next good byte 8'h12 received.
//   Low glitch of 5 cycles on idle line -> returns to IDLE, nothing pushed,
//     no error flags.
//   Assert rst_n mid-DATA with 2 bytes queued -> all outputs at reset values
//     immediately (async); next full frame received correctly.

Source files
------------

// File: rtl/cereal_rx.sv
// cereal_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit
// sampling FSM, small first-word-fall-through FIFO and frame/overrun flags.
module cereal_rx #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned AW           = 2
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       rxd,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned CNTW = AW + 1;
   localparam logic [CW-1:0]   HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]   FULL_M1   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAITHI
   } state_t;

   logic            r_sync1;
   logic            r_rx_s;
   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bitcnt;
   logic [7:0]      r_shreg;
   logic            r_busy;
   logic            r_frame_err;
   logic            r_overrun;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CNTW-1:0] r_count;
   logic            r_empty;
   logic            r_full;
   logic [7:0]      r_rd_data;

   state_t          w_state_n;
   logic [CW-1:0]   w_cnt_n;
   logic [2:0]      w_bitcnt_n;
   logic [7:0]      w_shreg_n;
   logic            w_push;
   logic            w_ferr;
   logic            w_pop;
   logic            w_wr;
   logic            w_ovf;
   logic [AW-1:0]   w_rd_ptr_n;
   logic [CNTW-1:0] w_count_n;
   logic [7:0]      w_head_n;

   // Two-flop synchronizer; the line idles high, so reset to 1.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_rx_s  <= r_sync1;
      end
   end

   // Receiver state, counters, shift register and status flags.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bitcnt    <= '0;
         r_shreg     <= '0;
         r_busy      <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_cnt       <= w_cnt_n;
         r_bitcnt    <= w_bitcnt_n;
         r_shreg     <= w_shreg_n;
         r_busy      <= (w_state_n != S_IDLE);
         r_frame_err <= w_ferr;
      end
   end

   // Next-state logic: start bit checked at half-bit, data/stop at bit end.
   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_bitcnt_n = r_bitcnt;
      w_shreg_n  = r_shreg;
      w_push     = 1'b0;
      w_ferr     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_n    = '0;
            w_bitcnt_n = '0;
            if (!r_rx_s) w_state_n = S_START;
         end
         S_START: begin
            if (r_cnt == HALF_M1) begin
               w_cnt_n   = '0;
               w_state_n = r_rx_s ? S_IDLE : S_DATA;
            end else begin
               w_cnt_n = r_cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_n   = '0;
               w_shreg_n = {r_rx_s, r_shreg[7:1]};
               if (r_bitcnt == 3'd7) begin
                  w_bitcnt_n = '0;
                  w_state_n  = S_STOP;
               end else begin
                  w_bitcnt_n = r_bitcnt + 3'd1;
               end
            end else begin
               w_cnt_n = r_cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_n = '0;
               if (r_rx_s) begin
                  w_push    = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  w_ferr    = 1'b1;
                  w_state_n = S_WAITHI;
               end
            end else begin
               w_cnt_n = r_cnt + CW'(1);
            end
         end
         S_WAITHI: begin
            w_cnt_n = '0;
            if (r_rx_s) w_state_n = S_IDLE;
         end
         default: begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
         end
      endcase
   end

   // FIFO control: pop ignored when empty, push allowed into a full FIFO only alongside a pop.
   always_comb begin
      w_pop      = rd_en && !r_empty;
      w_wr       = w_push && (!r_full || w_pop);
      w_ovf      = w_push && r_full && !rd_en;
      w_rd_ptr_n = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
      w_count_n  = r_count + CNTW'(w_wr) - CNTW'(w_pop);
      w_head_n   = (w_wr && (w_rd_ptr_n == r_wr_ptr)) ? r_shreg : r_mem[w_rd_ptr_n];
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge sysclk) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_shreg;
   end

   // FIFO pointers, occupancy flags and registered head word.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_empty   <= 1'b1;
         r_full    <= 1'b0;
         r_rd_data <= 8'h00;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr  <= w_rd_ptr_n;
         r_count   <= w_count_n;
         r_empty   <= (w_count_n == '0);
         r_full    <= (w_count_n == DEPTH_CNT);
         r_rd_data <= w_head_n;
      end
   end

   // Sticky overrun; a new drop beats a simultaneous clear.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n)       r_overrun <= 1'b0;
      else if (w_ovf)   r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
   end

   assign rd_data   = r_rd_data;
   assign empty     = r_empty;
   assign full      = r_full;
   assign busy      = r_busy;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule
